// File: rtl/count_ctrl.sv
// count_ctrl: start/pause/stop controlled up-counter with a limit latched at start.
// Optional feature: define COUNT_CTRL_AUTORELOAD_EN to wrap to 0 at the terminal
// count and keep running instead of parking in DONE.
module count_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             r,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] cnt_q, cnt_n;
  logic [WIDTH-1:0] lim_q, lim_n;
  logic             done_q, done_n;
  logic             busy_q, busy_n;

  // State, count, latched limit and registered flags
  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lim_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      lim_q   <= lim_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
    end
  end

  // Next-state and next-count decode; stop > pause > terminal/increment
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    lim_n   = lim_q;
    done_n  = 1'b0;
    busy_n  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (start) begin
          lim_n   = limit;
          state_n = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (pause) begin
          state_n = HOLD;
        end else if (cnt_q == lim_q) begin
          done_n = 1'b1;
`ifdef COUNT_CTRL_AUTORELOAD_EN
          cnt_n   = '0;
`else
          state_n = DONE;
`endif
        end else begin
          cnt_n = cnt_q + WIDTH'(1);
        end
      end
      HOLD: begin
        if (stop) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!pause) begin
          state_n = RUN;
        end
      end
      DONE: begin
        if (stop) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (start) begin
          lim_n   = limit;
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    busy_n = (state_n == RUN) || (state_n == HOLD);
  end

  assign out   = cnt_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule
